// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the multicycle CPU controller: ALU control codes,
// opcode / function-field constants, mux-select codes and the FSM state type.
// Ports: none (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  // ALU operation codes driven on ALUCtr
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Opcode field values
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type function field values
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // ALU B-operand select
  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_SHIMM = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states; the ADDI pair is only reachable when the ADDI option is built in
  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_MEMADR  = 4'd2,
    ST_MEMRD   = 4'd3,
    ST_MEMWB   = 4'd4,
    ST_MEMWR   = 4'd5,
    ST_REX     = 4'd6,
    ST_RWB     = 4'd7,
    ST_BEQ     = 4'd8,
    ST_JMP     = 4'd9,
    ST_ADDI_EX = 4'd10,
    ST_ADDI_WB = 4'd11
  } state_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_if
// Bundle between the multicycle controller and its datapath.
// Datapath -> controller: Op, Funct, Zero, mem_ready.
// Controller -> datapath: ALUCtr, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite,
//                         IRWrite, RegWrite, RegDst, MemtoReg, PCEn, PCSrc.
// Modports: master = controller side, slave = datapath side.
// -----------------------------------------------------------------------------
interface multicycle_ctrl_if;

  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       mem_ready;

  logic [3:0] ALUCtr;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       PCEn;
  logic [1:0] PCSrc;

  modport master (
    input  Op, Funct, Zero, mem_ready,
    output ALUCtr, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, RegDst, MemtoReg, PCEn, PCSrc
  );

  modport slave (
    output Op, Funct, Zero, mem_ready,
    input  ALUCtr, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
           RegWrite, RegDst, MemtoReg, PCEn, PCSrc
  );

endinterface

// File: rtl/multicycle_ctrl_alu_dec.sv
// -----------------------------------------------------------------------------
// alu_dec
// Maps the R-type function field to an ALU control code and flags whether the
// function is one the controller supports.
// Ports:
//   i_funct   [5:0] R-type function field
//   o_alu_ctr [3:0] ALU control code (add for unsupported functions)
//   o_valid         1 when i_funct is a supported R-type function
// -----------------------------------------------------------------------------
module alu_dec
  import cpu_pkg::*;
(
  input  logic [5:0] i_funct,
  output logic [3:0] o_alu_ctr,
  output logic       o_valid
);

  // Function-field decode
  always_comb begin
    o_alu_ctr = ALU_ADD;
    o_valid   = 1'b1;
    case (i_funct)
      FN_ADD:  o_alu_ctr = ALU_ADD;
      FN_SUB:  o_alu_ctr = ALU_SUB;
      FN_AND:  o_alu_ctr = ALU_AND;
      FN_OR:   o_alu_ctr = ALU_OR;
      FN_SLT:  o_alu_ctr = ALU_SLT;
      FN_NOR:  o_alu_ctr = ALU_NOR;
      default: begin
        o_alu_ctr = ALU_ADD;
        o_valid   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Main control FSM of a multicycle MIPS-style CPU (lw, sw, R-type, beq, j).
// Outputs are decoded from the state register; the exceptions are IRWrite/PCEn
// in FETCH (pulse on mem_ready) and PCEn in BEQ (follows Zero).
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset; also forces all strobes low while 0
//   bus    multicycle_ctrl_if.master (opcode/funct/flags in, controls out)
// Build option:
//   CTRL_ADDI_EN  when defined, opcode 001000 executes as addi (ADDI_EX ->
//                 ADDI_WB); otherwise it is treated as an illegal NOP.
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

`ifdef CTRL_ADDI_EN
  localparam logic ADDI_EN = 1'b1;
`else
  localparam logic ADDI_EN = 1'b0;
`endif

  state_e     r_state;
  state_e     w_next_state;

  logic [3:0] w_dec_alu_ctr;
  logic       w_dec_valid;

  logic [3:0] w_alu_ctr;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_reg_dst;
  logic       w_mem_to_reg;
  logic       w_pc_en;
  logic [1:0] w_pc_src;

  // The same decoder feeds the REX ALU code and the DECODE legality check
  alu_dec u_alu_dec (
    .i_funct   (bus.Funct),
    .o_alu_ctr (w_dec_alu_ctr),
    .o_valid   (w_dec_valid)
  );

  // State register with synchronous reset to FETCH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = ST_FETCH;
    case (r_state)
      ST_FETCH: begin
        if (bus.mem_ready) begin
          w_next_state = ST_DECODE;
        end else begin
          w_next_state = ST_FETCH;
        end
      end
      ST_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: w_next_state = ST_MEMADR;
          // Unsupported R-type functions abort here so nothing is written back
          OP_RTYPE:     w_next_state = w_dec_valid ? ST_REX : ST_FETCH;
          OP_BEQ:       w_next_state = ST_BEQ;
          OP_J:         w_next_state = ST_JMP;
          OP_ADDI:      w_next_state = ADDI_EN ? ST_ADDI_EX : ST_FETCH;
          default:      w_next_state = ST_FETCH;
        endcase
      end
      ST_MEMADR: begin
        if (bus.Op == OP_SW) begin
          w_next_state = ST_MEMWR;
        end else begin
          w_next_state = ST_MEMRD;
        end
      end
      ST_MEMRD: begin
        if (bus.mem_ready) begin
          w_next_state = ST_MEMWB;
        end else begin
          w_next_state = ST_MEMRD;
        end
      end
      ST_MEMWR: begin
        if (bus.mem_ready) begin
          w_next_state = ST_FETCH;
        end else begin
          w_next_state = ST_MEMWR;
        end
      end
      ST_REX:     w_next_state = ST_RWB;
      ST_ADDI_EX: w_next_state = ST_ADDI_WB;
      ST_MEMWB,
      ST_RWB,
      ST_BEQ,
      ST_JMP,
      ST_ADDI_WB: w_next_state = ST_FETCH;
      default:    w_next_state = ST_FETCH;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    w_alu_ctr    = ALU_ADD;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = SRCB_REGB;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_pc_en      = 1'b0;
    w_pc_src     = PCSRC_ALU;
    case (r_state)
      ST_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = SRCB_ONE;
        // IR load and PC+1 happen only in the cycle the read completes
        w_ir_write  = bus.mem_ready;
        w_pc_en     = bus.mem_ready;
      end
      ST_DECODE: begin
        w_alu_src_b = SRCB_SHIMM;
      end
      ST_MEMADR, ST_ADDI_EX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
      end
      ST_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      ST_REX: begin
        w_alu_src_a = 1'b1;
        w_alu_ctr   = w_dec_alu_ctr;
      end
      ST_RWB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
      end
      ST_BEQ: begin
        w_alu_src_a = 1'b1;
        w_alu_ctr   = ALU_SUB;
        w_pc_src    = PCSRC_ALUOUT;
        w_pc_en     = bus.Zero;
      end
      ST_JMP: begin
        w_pc_src = PCSRC_JUMP;
        w_pc_en  = 1'b1;
      end
      ST_ADDI_WB: begin
        w_reg_write = 1'b1;
      end
      default: begin
        w_alu_ctr = ALU_ADD;
      end
    endcase
  end

  // Strobes are gated by rst_n so an aborted instruction cannot write anything
  assign bus.MemRead  = w_mem_read  & rst_n;
  assign bus.MemWrite = w_mem_write & rst_n;
  assign bus.IRWrite  = w_ir_write  & rst_n;
  assign bus.PCEn     = w_pc_en     & rst_n;
  assign bus.RegWrite = w_reg_write & rst_n;

  assign bus.ALUCtr   = w_alu_ctr;
  assign bus.ALUSrcA  = w_alu_src_a;
  assign bus.ALUSrcB  = w_alu_src_b;
  assign bus.IorD     = w_iord;
  assign bus.RegDst   = w_reg_dst;
  assign bus.MemtoReg = w_mem_to_reg;
  assign bus.PCSrc    = w_pc_src;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Builds, for each instruction, the expected per-cycle control outputs from the
// instruction's phase sequence, drives the matching mem_ready/Zero/rst_n
// pattern, and compares the controller outputs cycle by cycle.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multicycle_ctrl_if ifc ();

  multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  // Bench-owned encodings
  localparam logic [3:0] E_ADD = 4'b0010;
  localparam logic [3:0] E_SUB = 4'b0110;
  localparam logic [3:0] E_AND = 4'b0000;
  localparam logic [3:0] E_OR  = 4'b0001;
  localparam logic [3:0] E_SLT = 4'b0111;
  localparam logic [3:0] E_NOR = 4'b1100;

  typedef struct packed {
    logic [3:0] alu;
    logic       srca;
    logic [1:0] srcb;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rw;
    logic       rdst;
    logic       m2r;
    logic       pcen;
    logic [1:0] pcsrc;
  } ov_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    bit         mr;
    bit         zr;
    bit         rst;
    ov_t        exp;
    ov_t        care;
    string      tag;
  } step_t;

  step_t      instr_q[$];
  logic [5:0] cur_op;
  logic [5:0] cur_funct;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  function automatic ov_t base_exp();
    ov_t e = '0;
    e.alu = E_ADD;
    return e;
  endfunction

  // ALU code and strobes are always specified; mux selects only where stated
  function automatic ov_t base_care();
    ov_t c = '0;
    c.alu  = 4'hF;
    c.mrd  = 1'b1;
    c.mwr  = 1'b1;
    c.irw  = 1'b1;
    c.rw   = 1'b1;
    c.pcen = 1'b1;
    return c;
  endfunction

  function automatic ov_t get_obs();
    ov_t o;
    o.alu   = ifc.ALUCtr;
    o.srca  = ifc.ALUSrcA;
    o.srcb  = ifc.ALUSrcB;
    o.iord  = ifc.IorD;
    o.mrd   = ifc.MemRead;
    o.mwr   = ifc.MemWrite;
    o.irw   = ifc.IRWrite;
    o.rw    = ifc.RegWrite;
    o.rdst  = ifc.RegDst;
    o.m2r   = ifc.MemtoReg;
    o.pcen  = ifc.PCEn;
    o.pcsrc = ifc.PCSrc;
    return o;
  endfunction

  // {valid, code} for an R-type function field
  function automatic logic [4:0] funct_code(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, E_ADD};
      6'b100010: return {1'b1, E_SUB};
      6'b100100: return {1'b1, E_AND};
      6'b100101: return {1'b1, E_OR};
      6'b101010: return {1'b1, E_SLT};
      6'b100111: return {1'b1, E_NOR};
      default:   return {1'b0, E_ADD};
    endcase
  endfunction

  task automatic push(input ov_t e, input ov_t c, input bit mr, input bit zr, input string tag);
    step_t s;
    s.op = cur_op; s.funct = cur_funct; s.mr = mr; s.zr = zr; s.rst = 1'b1;
    s.exp = e; s.care = c; s.tag = tag;
    instr_q.push_back(s);
  endtask

  // Memory phase: wait_n cycles with mem_ready low, then one completing cycle
  task automatic ph_fetch(input int wait_n);
    ov_t e, c;
    for (int i = 0; i <= wait_n; i++) begin
      e = base_exp(); c = base_care();
      e.mrd = 1'b1;
      c.iord = 1'b1; c.srca = 1'b1; c.srcb = 2'b11; c.pcsrc = 2'b11;
      e.srcb = 2'b01;
      if (i == wait_n) begin
        e.irw = 1'b1; e.pcen = 1'b1;
      end
      push(e, c, (i == wait_n), rb(), "fetch");
    end
  endtask

  task automatic ph_simple(input string which, input bit zr_in);
    ov_t e, c;
    bit  zr = rb();
    e = base_exp(); c = base_care();
    case (which)
      "decode": begin
        c.srca = 1'b1; c.srcb = 2'b11; e.srcb = 2'b11;
      end
      "memadr", "addi_ex": begin
        c.srca = 1'b1; c.srcb = 2'b11; e.srca = 1'b1; e.srcb = 2'b10;
      end
      "memwb": begin
        e.rw = 1'b1; e.m2r = 1'b1; c.rdst = 1'b1; c.m2r = 1'b1;
      end
      "rwb": begin
        e.rw = 1'b1; e.rdst = 1'b1; c.rdst = 1'b1; c.m2r = 1'b1;
      end
      "addi_wb": begin
        e.rw = 1'b1; c.rdst = 1'b1; c.m2r = 1'b1;
      end
      "beq": begin
        zr = zr_in;
        e.alu = E_SUB; e.srca = 1'b1; e.pcsrc = 2'b01; e.pcen = zr_in;
        c.srca = 1'b1; c.srcb = 2'b11; c.pcsrc = 2'b11;
      end
      "jmp": begin
        e.pcsrc = 2'b10; e.pcen = 1'b1; c.pcsrc = 2'b11;
      end
      default: ;
    endcase
    push(e, c, rb(), zr, which);
  endtask

  task automatic ph_rex(input logic [3:0] code);
    ov_t e, c;
    e = base_exp(); c = base_care();
    e.alu = code; e.srca = 1'b1;
    c.srca = 1'b1; c.srcb = 2'b11;
    push(e, c, rb(), rb(), "rex");
  endtask

  task automatic ph_mem(input bit is_write, input int wait_n);
    ov_t e, c;
    for (int i = 0; i <= wait_n; i++) begin
      e = base_exp(); c = base_care();
      e.iord = 1'b1; c.iord = 1'b1;
      if (is_write) e.mwr = 1'b1;
      else          e.mrd = 1'b1;
      push(e, c, (i == wait_n), rb(), is_write ? "memwr" : "memrd");
    end
  endtask

  // Expected cycle sequence of one instruction; zb<0 picks a random Zero in BEQ
  task automatic build(input logic [5:0] op, input logic [5:0] funct,
                       input int fw, input int mw, input int zb);
    logic [4:0] fc;
    instr_q.delete();
    cur_op = op; cur_funct = funct;
    ph_fetch(fw);
    ph_simple("decode", 1'b0);
    case (op)
      6'b100011: begin
        ph_simple("memadr", 1'b0); ph_mem(1'b0, mw); ph_simple("memwb", 1'b0);
      end
      6'b101011: begin
        ph_simple("memadr", 1'b0); ph_mem(1'b1, mw);
      end
      6'b000000: begin
        fc = funct_code(funct);
        if (fc[4]) begin
          ph_rex(fc[3:0]); ph_simple("rwb", 1'b0);
        end
      end
      6'b000100: ph_simple("beq", (zb < 0) ? rb() : bit'(zb));
      6'b000010: ph_simple("jmp", 1'b0);
`ifdef CTRL_ADDI_EN
      6'b001000: begin
        ph_simple("addi_ex", 1'b0); ph_simple("addi_wb", 1'b0);
      end
`endif
      default: ;
    endcase
  endtask

  // Run the built instruction; cut>=0 replaces step 'cut' by a reset cycle
  task automatic commit_run(input int cut);
    step_t s;
    ov_t   c;
    int    n = instr_q.size();
    if (cut >= 0 && cut < n) begin
      s = instr_q[cut];
      c = base_care(); c.alu = 4'h0;
      s.exp = '0; s.care = c; s.rst = 1'b0; s.mr = 1'b1; s.zr = 1'b1; s.tag = "reset";
      instr_q[cut] = s;
      n = cut + 1;
    end
    for (int i = 0; i < n; i++) begin
      s = instr_q[i];
      ifc.Op = s.op; ifc.Funct = s.funct; ifc.mem_ready = s.mr; ifc.Zero = s.zr;
      rst_n = s.rst;
      #4;
      check_eq(s.tag, 32'(get_obs() & s.care), 32'(s.exp & s.care));
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
  endtask

  logic [5:0] ops[7];
  logic [5:0] fns[6];

  initial begin
    logic [5:0] op, fn;
    int cut;
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};

    rst_n = 1'b0;
    ifc.Op = 6'b000000; ifc.Funct = 6'b000000; ifc.Zero = 1'b1; ifc.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_strobes",
             {27'd0, ifc.MemRead, ifc.MemWrite, ifc.IRWrite, ifc.PCEn, ifc.RegWrite}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases
    build(6'b000000, 6'b100010, 0, 0, -1); commit_run(-1);   // R-type sub
    build(6'b100011, 6'b000000, 0, 3, -1); commit_run(-1);   // lw, 3 wait cycles
    build(6'b000100, 6'b000000, 0, 0,  1); commit_run(-1);   // beq taken
    build(6'b000100, 6'b000000, 0, 0,  0); commit_run(-1);   // beq not taken
    build(6'b111111, 6'b000000, 0, 0, -1); commit_run(-1);   // illegal
    build(6'b000000, 6'b111111, 1, 0, -1); commit_run(-1);   // bad funct
    build(6'b101011, 6'b000000, 0, 2, -1); commit_run(3);    // reset in MEMWR
    build(6'b101011, 6'b000000, 2, 1, -1); commit_run(-1);   // sw
    build(6'b000010, 6'b000000, 0, 0, -1); commit_run(-1);   // j
    build(6'b001000, 6'b000000, 0, 0, -1); commit_run(-1);   // addi / NOP

    // Randomized instruction stream
    for (int k = 0; k < 200; k++) begin
      op = ops[$urandom_range(0, 6)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      fn = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 5) == 0) fn = 6'($urandom_range(0, 63));
      build(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), -1);
      cut = ($urandom_range(0, 7) == 0) ? $urandom_range(0, instr_q.size() - 1) : -1;
      commit_run(cut);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameters: none; all encodings come from the shared package.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 Op  input  6  instruction opcode field from the instruction register.
REQ-005 Funct  input  6  R-type function field from the instruction register.
REQ-006 Zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory handshake; high means the current read/write completes this cycle.
REQ-008 ALUCtr  output  4  ALU op: add 0010, sub 0110, and 0000, or 0001, slt 0111, nor 1100.
REQ-009 ALUSrcA  output  1  0=PC, 1=register A.
REQ-010 ALUSrcB  output  2  00=reg B, 01=const 1, 10=sign-ext imm, 11=shifted imm.
REQ-011 IorD, MemRead, MemWrite, IRWrite  output  1 each  memory address select and strobes.
REQ-012 RegWrite, RegDst, MemtoReg  output  1 each  register-file write controls.
REQ-013 PCEn  output  1  PC load enable; PCSrc  output  2  00=ALU, 01=ALUOut, 10=jump target.

Function
REQ-014 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, REX, RWB, BEQ, JMP (+ADDI_EX, ADDI_WB per REQ-027); Moore outputs from the state register, except PCEn in BEQ.
REQ-015 FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUCtr=add, PCSrc=00; IRWrite and PCEn pulse only in the cycle mem_ready=1, then go to DECODE; otherwise hold in FETCH.
REQ-016 DECODE: ALUSrcA=0, ALUSrcB=11, ALUCtr=add; next state by Op: 100011/101011→MEMADR, 000000→REX, 000100→BEQ, 000010→JMP; any other Op→FETCH (NOP).
REQ-017 R-type with an unsupported Funct (not 100000/100010/100100/100101/101010/100111) SHALL go DECODE→FETCH with no register write.
REQ-018 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUCtr=add; next MEMRD for lw, MEMWR for sw.
REQ-019 MEMRD: IorD=1, MemRead=1; hold until mem_ready, then MEMWB; MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, then FETCH.
REQ-020 MEMWR: IorD=1, MemWrite=1; hold until mem_ready, then FETCH.
REQ-021 REX: ALUSrcA=1, ALUSrcB=00, ALUCtr from Funct (add/sub/and/or/slt/nor); RWB: RegWrite=1, RegDst=1, MemtoReg=0, then FETCH.
REQ-022 BEQ: ALUSrcA=1, ALUSrcB=00, ALUCtr=sub, PCSrc=01, PCEn=Zero (combinational); then FETCH.
REQ-023 JMP: PCSrc=10, PCEn=1; then FETCH.
REQ-024 Strobes not listed for a state SHALL be 0; the ALUCtr default SHALL be add.
REQ-025 Latency with mem_ready held high: lw 5, sw 4, R-type 4, beq 3, j 3, illegal 2 cycles.

Reset
REQ-026 While rst_n=0 at a clock edge, the state SHALL become FETCH, and all strobes (MemRead, MemWrite, IRWrite, PCEn, RegWrite) SHALL be 0 during any cycle where rst_n=0; reset mid-instruction aborts it without a pending write.

Configuration
REQ-027 Macro CTRL_ADDI_EN: when defined, Op 001000 goes DECODE→ADDI_EX (ALUSrcA=1, ALUSrcB=10, add)→ADDI_WB (RegWrite=1, RegDst=0, MemtoReg=0)→FETCH; when undefined, Op 001000 is an illegal NOP (REQ-016).

Structure
REQ-028 Shared package cpu_pkg SHALL hold the ALUCtr codes, Op/Funct constants and the state enum typedef.
REQ-029 Sub-module alu_dec (Funct→ALUCtr, valid flag) SHALL be instantiated for REX and for the REQ-017 check.

Verification
REQ-030 Op=000000, Funct=100010, mem_ready=1 → FETCH,DECODE,REX(ALUCtr=0110),RWB(RegWrite=1,RegDst=1),FETCH.
REQ-031 Op=100011 with mem_ready low for 3 cycles in MEMRD → MemRead=1 and IorD=1 held for 4 cycles, then MEMWB MemtoReg=1.
REQ-032 Op=000100 with Zero=1 → PCEn=1 and PCSrc=01 in BEQ; with Zero=0 → PCEn=0.
REQ-033 Op=111111 → FETCH,DECODE,FETCH with no MemWrite or RegWrite.
REQ-034 rst_n=0 asserted in MEMWR → MemWrite=0 that cycle; FETCH after release.
REQ-035 Op=001000 → 4-cycle writeback with CTRL_ADDI_EN defined; NOP without it.
